// File: rtl/fifo_wctl_if.sv
// fifo_wctl_if: write-side bus of the async FIFO write controller.
//   winc     : write request from the producer
//   wq2_rptr : Gray read pointer already synchronized into the write clock
//   waddr    : memory write address
//   wclken   : memory write enable
//   wptr     : registered Gray write pointer (to the read-side synchronizer)
//   wfull    : full flag
//   wafull   : almost-full flag
//   wlevel   : fill level, 0..DEPTH
//   wovf     : sticky overflow flag (only with FIFO_WOVF_EN)
// Modports: master = write controller, slave = producer / environment.
interface fifo_wctl_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE-1:0] waddr;
  logic                wclken;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
`ifdef FIFO_WOVF_EN
  logic                wovf;

  modport master (input  winc, wq2_rptr,
                  output waddr, wclken, wptr, wfull, wafull, wlevel, wovf);
  modport slave  (output winc, wq2_rptr,
                  input  waddr, wclken, wptr, wfull, wafull, wlevel, wovf);
`else
  modport master (input  winc, wq2_rptr,
                  output waddr, wclken, wptr, wfull, wafull, wlevel);
  modport slave  (output winc, wq2_rptr,
                  input  waddr, wclken, wptr, wfull, wafull, wlevel);
`endif
endinterface

// File: rtl/fifo_wctl.sv
// fifo_wctl: write-side control of the asynchronous FIFO.
// Owns the binary/Gray write pointer, gates writes into the dual-port memory
// and derives full / almost-full / level from the synchronized read pointer.
// Ports:
//   wclk : write clock (only clock)
//   wrst : synchronous active-high reset
//   bus  : fifo_wctl_if.master (winc, wq2_rptr in; waddr, wclken, wptr,
//          wfull, wafull, wlevel, [wovf] out)
// Parameters: ADDRSIZE (DEPTH = 2**ADDRSIZE), AFULL_THRESH (1..DEPTH).
// Optional feature macro: FIFO_WOVF_EN adds the sticky overflow flag wovf.
module fifo_wctl #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic       wclk,
  input  logic       wrst,
  fifo_wctl_if.master bus
);
  localparam logic [ADDRSIZE:0] AFULL_T = AFULL_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              wafull_q, wafull_d;
  logic [ADDRSIZE:0] rbin;
  logic              wclken;

  // Enable depends only on winc and the registered full flag; the
  // synchronized read pointer never reaches the memory write enable.
  assign wclken = bus.winc & ~wfull_q & ~wrst;

  // Gray -> binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) rbin[i] = ^(bus.wq2_rptr >> i);
  end

  always_comb begin
    wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, wclken};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    // Full when the next Gray pointer equals the read pointer with its two
    // MSBs inverted (one full lap ahead).
    wfull_d  = (wptr_d == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                            bus.wq2_rptr[ADDRSIZE-2:0]});
    // Modulo subtraction; the lagging read pointer only over-reports.
    wlevel_d = wbin_d - rbin;
    wafull_d = (wlevel_d >= AFULL_T);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wlevel_q <= wlevel_d;
    end
  end

`ifdef FIFO_WOVF_EN
  logic wovf_q;
  // Sticky: any request that arrives while full is recorded until reset.
  always_ff @(posedge wclk) begin
    if (wrst)                        wovf_q <= 1'b0;
    else if (bus.winc && wfull_q)    wovf_q <= 1'b1;
  end
  assign bus.wovf = wovf_q;
`endif

  assign bus.waddr  = wbin_q[ADDRSIZE-1:0];
  assign bus.wclken = wclken;
  assign bus.wptr   = wptr_q;
  assign bus.wfull  = wfull_q;
  assign bus.wafull = wafull_q;
  assign bus.wlevel = wlevel_q;
endmodule

// File: tb/tb_fifo_wctl.sv
// tb_fifo_wctl: randomized + directed bench for fifo_wctl.
// Reference model tracks plain integer write/read counts; pointers, level
// and flags are derived from them arithmetically.
module tb_fifo_wctl;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 12;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  fifo_wctl_if #(.ADDRSIZE(AW)) bus ();
  fifo_wctl #(.ADDRSIZE(AW), .AFULL_THRESH(AF)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int wcnt = 0;   // total accepted writes since reset
  int rcnt = 0;   // total reads visible through wq2_rptr since reset
  int m_level = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];  // modulo 2^(AW+1)
    return b ^ (b >> 1);
  endfunction

  // One clock: drive inputs, check combinational outputs, clock, check state.
  task automatic step(input bit inc, input int radv, input bit rst);
    bit acc;
    @(negedge wclk);
    if (rst) rcnt = 0;
    else     rcnt += radv;
    wrst         = rst;
    bus.winc     = inc;
    bus.wq2_rptr = gray(rcnt);
    #1;
    acc = inc && !m_full && !rst;
    chk("wclken", bus.wclken, acc);
    chk("waddr_pre", bus.waddr, wcnt % DEPTH);
    if (rst) begin
      wcnt = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      if (inc && m_full) m_ovf = 1;
      if (acc) wcnt++;
      m_level = wcnt - rcnt;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= AF);
    end
    @(posedge wclk);
    #1;
    chk("waddr",  bus.waddr,  wcnt % DEPTH);
    chk("wptr",   bus.wptr,   gray(wcnt));
    chk("wfull",  bus.wfull,  m_full);
    chk("wafull", bus.wafull, m_afull);
    chk("wlevel", bus.wlevel, m_level);
`ifdef FIFO_WOVF_EN
    chk("wovf",   bus.wovf,   m_ovf);
`endif
  endtask

  initial begin
    bus.winc     = 1'b1;
    bus.wq2_rptr = '0;

    // reset with winc held high
    step(1, 0, 1);
    chk("rst_level", bus.wlevel, 0);

    // fill 16
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0);
      if (i == AF - 2) chk("afull_pre12", bus.wafull, 0);
      if (i == AF - 1) chk("afull_at12",  bus.wafull, 1);
    end
    chk("fill_wptr",  bus.wptr,  5'b11000);
    chk("fill_full",  bus.wfull, 1);
    chk("fill_waddr", bus.waddr, 0);
    chk("fill_level", bus.wlevel, 16);

    // overflow attempts
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    chk("ovf_wptr",  bus.wptr,   5'b11000);
    chk("ovf_level", bus.wlevel, 16);
`ifdef FIFO_WOVF_EN
    chk("ovf_flag", bus.wovf, 1);
`endif

    // wrap: reader saw all 16, write 16 more
    step(0, 16, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    chk("wrap_wptr",  bus.wptr,   5'b00000);
    chk("wrap_full",  bus.wfull,  1);
    chk("wrap_level", bus.wlevel, 16);

    // release race: read advance and write in same cycle while full
    step(1, 1, 0);
    chk("race_full",  bus.wfull,  0);
    chk("race_level", bus.wlevel, 15);
    step(1, 0, 0);
    chk("race_refull", bus.wfull, 1);

    // mid-operation reset at level 7
    step(0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    chk("mid_level7", bus.wlevel, 7);
    step(0, 0, 1);
    chk("mid_rst_level", bus.wlevel, 0);
    chk("mid_rst_wptr",  bus.wptr,   0);
    step(1, 0, 0);
    chk("mid_first_waddr_next", bus.waddr, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit inc, rst;
      int radv;
      inc  = ($urandom_range(0, 3) != 0);
      radv = $urandom_range(0, 2);
      if (rcnt + radv > wcnt) radv = wcnt - rcnt;
      if (i % 97 == 50) radv = 0;       // stall reader to reach full
      rst  = ($urandom_range(0, 149) == 0);
      step(inc, radv, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wctl.md
# fifo_wctl

Write-side control for the asynchronous FIFO: owns the write pointer and drives the dual-port memory's write address and write enable. Converts `winc` into a guarded memory write, keeps binary and Gray write pointers, and compares against the read pointer already synchronized into `wclk` to produce full, almost-full and fill-level status. Sits directly upstream of the FIFO memory, in the write clock domain.

## Interface
- `ADDRSIZE`, 4: memory address bits; DEPTH = 2^ADDRSIZE.
- `AFULL_THRESH`, 12: `wafull` asserts when level >= this value; legal range 1..DEPTH.

- `wclk`  in  1  write clock; the only clock.
- `wrst`  in  1  reset, synchronous, active-high.
- `winc`  in  1  write request; data accompanies it at the memory.
- `wq2_rptr`  in  ADDRSIZE+1  Gray read pointer, already synchronized into `wclk`; no synchronizer inside this block.
- `waddr`  out  ADDRSIZE  memory write address, `wbin[ADDRSIZE-1:0]`.
- `wclken`  out  1  memory write enable = `winc & ~wfull`, combinational.
- `wptr`  out  ADDRSIZE+1  registered Gray write pointer, sent to the read-side synchronizer.
- `wfull`  out  1  registered full flag.
- `wafull`  out  1  registered almost-full flag.
- `wlevel`  out  ADDRSIZE+1  registered fill level, 0..DEPTH.
- `wovf`  out  1  sticky overflow flag; present only with `FIFO_WOVF_EN`.

## Operation
- State: `wbin` (ADDRSIZE+1 binary), `wptr` (Gray), `wfull`, `wafull`, `wlevel`.
- `wbinnext = wbin + wclken`, modulo 2^(ADDRSIZE+1). `wgraynext = (wbinnext>>1) ^ wbinnext`.
- Full: `wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]})`.
- Level: `rbin = gray2bin(wq2_rptr)`. `wlevel_next = (wbinnext - rbin)` modulo 2^(ADDRSIZE+1). Never exceeds DEPTH.
- `wafull_next = (wlevel_next >= AFULL_THRESH)`.
- Write accepted iff `winc=1` and registered `wfull=0`. A request while full is dropped: no memory write, no pointer change.
- Status is pessimistic. `wq2_rptr` lags the true read pointer, so `wlevel` can only over-report and `wfull` can only linger. `wfull` deasserts only after `wq2_rptr` advances.
- Wrap-around: `wbin` wraps from 2^(ADDRSIZE+1)-1 to 0. The MSB toggles once per DEPTH writes and distinguishes full from empty.

## Timing
- Every edge of `wclk`: `wbin`, `wptr`, `wfull`, `wafull`, `wlevel` load their `_next` values.
- Write latency: an accepted `winc` at edge N writes `mem[waddr]` at edge N. `waddr`, `wptr`, `wfull`, `wlevel` reflect it after edge N.
- `wclken` is combinational from `winc` and registered `wfull`. There is no combinational path from `wq2_rptr` to `wclken`.
- Simultaneous `winc` with a `wq2_rptr` advance while full: the write is blocked that cycle. `wfull` clears after the edge, and the next `winc` is accepted.
- Reset (`wrst=1` at an edge): `wbin=0`, `wptr=0`, `wfull=0`, `wafull=0`, `wlevel=0`, `wovf=0`.
  - `waddr=0` after reset.
  - `wclken` is forced to 0 while `wrst=1`.
  - Reset mid-operation discards the level immediately. The read domain must be reset in the same window.

## Configuration
- `FIFO_WOVF_EN` defined:
  - `wovf` port exists.
  - Set on any edge where `winc=1` and `wfull=1`.
  - Cleared only by `wrst`.
- Not defined: the `wovf` port and its register are absent. Dropped writes are silent; all other behaviour is identical.

## Test plan
Defaults for all scenarios: ADDRSIZE=4, AFULL_THRESH=12.
- Reset: `wrst=1` for 1 cycle with `winc=1` -> all outputs 0, `wclken=0`, no memory write.
- Fill: `wq2_rptr=0`, `winc=1` for 16 cycles ->
  - `wafull=1` after the 12th write.
  - After the 16th write: `wfull=1`, `wlevel=16`, `wptr=5'b11000`, `waddr=0`.
- Overflow: full, `winc=1` for 3 cycles -> `wclken=0`, `wptr` unchanged, `wlevel=16`, `wovf=1` stays set (macro on).
- Wrap: full with `wq2_rptr=5'b11000` (16 reads seen), 16 more writes -> `wbin` wraps 31->0, `wptr=5'b00000`, `wfull=1`, `wlevel=16`.
- Release race: full, `wq2_rptr` advances by one Gray step in the same cycle as `winc=1` ->
  - Write blocked that cycle.
  - Next cycle: `wfull=0`, `wlevel=15`.
  - Following `winc` accepted; `wfull=1` again after that edge.
- Mid-operation reset: `wlevel=7`, assert `wrst` -> next cycle all outputs 0; first write after release goes to `waddr=0`.
